// File: rtl/approx_err_monitor.sv
// ============================================================================
// approx_err_monitor : two-stage error-distance monitor for an approximate adder
// Optional: APPROX_ERR_MAXCAPTURE_EN keeps the operands of the max-ED sample.
// Revision: 1.0
// ============================================================================
`default_nettype none

module approx_err_monitor #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 32,
    parameter int ACC_W = 48
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH:0]   in_sum,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_ed,
    output logic             out_over,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [WIDTH:0]   max_ed,
    output logic [ACC_W-1:0] sum_ed,
    output logic [WIDTH-1:0] max_a,
    output logic [WIDTH-1:0] max_b
);

    // Accumulator add is done one bit wider than the larger operand so overflow is visible.
    localparam int SUM_W = ((ACC_W > WIDTH + 1) ? ACC_W : WIDTH + 1) + 1;

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH:0]   s1_exact_q, s1_exact_d;
    logic [WIDTH:0]   s1_approx_q, s1_approx_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH:0]   out_ed_q, out_ed_d;
    logic             out_over_q, out_over_d;
    logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [WIDTH:0]   max_ed_q, max_ed_d;
    logic [ACC_W-1:0] sum_ed_q, sum_ed_d;

    logic             s1_load, s2_load, max_upd;
    logic [WIDTH+1:0] diff, diff_abs;
    logic [WIDTH:0]   s2_ed;
    logic [CNT_W-1:0] cnt_base, err_base;
    logic [WIDTH:0]   max_base;
    logic [ACC_W-1:0] sum_base;
    logic [SUM_W-1:0] sum_wide;

    always_comb begin
        s2_load  = s1_valid_q && (!out_valid_q || out_ready);
        in_ready = !s1_valid_q || s2_load;
        s1_load  = in_valid && in_ready;

        s1_valid_d  = s1_load ? 1'b1 : (s2_load ? 1'b0 : s1_valid_q);
        s1_exact_d  = s1_load ? ({1'b0, in_a} + {1'b0, in_b}) : s1_exact_q;
        s1_approx_d = s1_load ? in_sum : s1_approx_q;

        diff     = {1'b0, s1_exact_q} - {1'b0, s1_approx_q};
        diff_abs = diff[WIDTH+1] ? (~diff + 1'b1) : diff;
        s2_ed    = diff_abs[WIDTH:0];

        out_valid_d = s2_load ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
        out_ed_d    = s2_load ? s2_ed : out_ed_q;
        out_over_d  = s2_load ? diff[WIDTH+1] : out_over_q;
    end

    // clear wipes the stored statistics first, so a coinciding sample starts a fresh set.
    always_comb begin
        cnt_base = clear ? '0 : sample_cnt_q;
        err_base = clear ? '0 : err_cnt_q;
        max_base = clear ? '0 : max_ed_q;
        sum_base = clear ? '0 : sum_ed_q;

        sample_cnt_d = cnt_base;
        err_cnt_d    = err_base;
        max_ed_d     = max_base;
        sum_ed_d     = sum_base;
        max_upd      = 1'b0;
        sum_wide     = SUM_W'(sum_base) + SUM_W'(s2_ed);

        if (s2_load) begin
            if (cnt_base != '1) sample_cnt_d = cnt_base + CNT_W'(1);
            if ((s2_ed != '0) && (err_base != '1)) err_cnt_d = err_base + CNT_W'(1);
            sum_ed_d = (sum_wide > SUM_W'({ACC_W{1'b1}})) ? '1 : sum_wide[ACC_W-1:0];
            if (s2_ed > max_base) begin
                max_ed_d = s2_ed;
                max_upd  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_exact_q   <= '0;
            s1_approx_q  <= '0;
            out_valid_q  <= 1'b0;
            out_ed_q     <= '0;
            out_over_q   <= 1'b0;
            sample_cnt_q <= '0;
            err_cnt_q    <= '0;
            max_ed_q     <= '0;
            sum_ed_q     <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_exact_q   <= s1_exact_d;
            s1_approx_q  <= s1_approx_d;
            out_valid_q  <= out_valid_d;
            out_ed_q     <= out_ed_d;
            out_over_q   <= out_over_d;
            sample_cnt_q <= sample_cnt_d;
            err_cnt_q    <= err_cnt_d;
            max_ed_q     <= max_ed_d;
            sum_ed_q     <= sum_ed_d;
        end
    end

`ifdef APPROX_ERR_MAXCAPTURE_EN
    logic [WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic [WIDTH-1:0] max_a_q, max_a_d, max_b_q, max_b_d;

    always_comb begin
        s1_a_d  = s1_load ? in_a : s1_a_q;
        s1_b_d  = s1_load ? in_b : s1_b_q;
        max_a_d = clear ? '0 : max_a_q;
        max_b_d = clear ? '0 : max_b_q;
        if (max_upd) begin
            max_a_d = s1_a_q;
            max_b_d = s1_b_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_a_q  <= '0;
            s1_b_q  <= '0;
            max_a_q <= '0;
            max_b_q <= '0;
        end else begin
            s1_a_q  <= s1_a_d;
            s1_b_q  <= s1_b_d;
            max_a_q <= max_a_d;
            max_b_q <= max_b_d;
        end
    end

    assign max_a = max_a_q;
    assign max_b = max_b_q;
`else
    logic unused_max_upd;
    assign unused_max_upd = max_upd;
    assign max_a = '0;
    assign max_b = '0;
`endif

    assign out_valid  = out_valid_q;
    assign out_ed     = out_ed_q;
    assign out_over   = out_over_q;
    assign sample_cnt = sample_cnt_q;
    assign err_cnt    = err_cnt_q;
    assign max_ed     = max_ed_q;
    assign sum_ed     = sum_ed_q;

endmodule

`default_nettype wire
